// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader : boot-time byte-stream loader for the instruction memory |
// | Optional trailing XOR checksum: define IMEM_LOADER_CHECKSUM_EN        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_loader #(
  parameter int INST_MEM_DEPTH = 256,
  parameter int width          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [width-1:0]   in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [4*width-1:0] mem_wd,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [15:0]        words_loaded
);

  localparam logic [15:0] c_max_words = 16'(INST_MEM_DEPTH / 4);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_len  = 3'd1;
  localparam logic [2:0] c_st_load = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] c_st_chk  = 3'd3;
`endif
  localparam logic [2:0] c_st_done = 3'd4;
  localparam logic [2:0] c_st_err  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [3*width-1:0] word_q, word_d;
  logic [15:0]        n_q, n_d;
  logic [15:0]        words_q, words_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [4*width-1:0] mem_wd_q, mem_wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [width-1:0]   csum_q, csum_d;
`else
  // Set for the single cycle in which the final write issues; stalls the stream.
  logic               drain_q, drain_d;
`endif

  logic        w_accept;
  logic [15:0] w_len;
  logic        w_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy     = (state_q == c_st_len) || (state_q == c_st_load) || (state_q == c_st_chk);
  assign in_ready = busy;
`else
  assign busy     = (state_q == c_st_len) || (state_q == c_st_load);
  assign in_ready = busy && !drain_q;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_len    = {n_q[15:8], in_data[7:0]};
  // Earlier word writes have always retired before the 4th byte of the next word.
  assign w_last   = ((words_q + 16'd1) == n_q);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    n_d        = n_q;
    words_d    = mem_we_q ? (words_q + 16'd1) : words_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`else
    drain_d    = 1'b0;
`endif

    case (state_q)
      c_st_idle, c_st_done, c_st_err: begin
        if (start) begin
          state_d    = c_st_len;
          byte_cnt_d = 2'd0;
          word_d     = '0;
          n_d        = 16'd0;
          words_d    = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end

      c_st_len: begin
        if (w_accept) begin
          if (byte_cnt_q == 2'd0) begin
            n_d        = {in_data[7:0], 8'h00};
            byte_cnt_d = 2'd1;
          end else begin
            n_d        = w_len;
            byte_cnt_d = 2'd0;
            if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = c_st_chk;
`else
              state_d = c_st_done;
`endif
            end else if (w_len > c_max_words) begin
              state_d = c_st_err;
            end else begin
              state_d = c_st_load;
            end
          end
        end
      end

      c_st_load: begin
        if (w_accept) begin
          word_d     = {word_q[2*width-1:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d   = 1'b1;
            mem_addr_d = {14'd0, words_q, 2'b00};
            mem_wd_d   = {word_q, in_data};
            if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = c_st_chk;
`else
              drain_d = 1'b1;
`endif
            end
          end
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (drain_q) begin
          state_d = c_st_done;
        end
`endif
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      c_st_chk: begin
        if (w_accept) begin
          state_d = (in_data == csum_q) ? c_st_done : c_st_err;
        end
      end
`endif

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= c_st_idle;
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
      n_q        <= 16'd0;
      words_q    <= 16'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_wd_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`else
      drain_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      n_q        <= n_d;
      words_q    <= words_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`else
      drain_q    <= drain_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wd       = mem_wd_q;
  assign done         = (state_q == c_st_done);
  assign error        = (state_q == c_st_err);
  assign cpu_rst      = done;
  assign words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader : randomized scoreboard bench for imem_loader          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int MAXW  = DEPTH / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_rst, busy, done, error;
  logic [31:0] mem_addr, mem_wd;
  logic [15:0] words_loaded;

  imem_loader #(.INST_MEM_DEPTH(DEPTH), .width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", mem_addr, mon_e.addr);
        check("write_data", mem_wd, mon_e.data);
        check("write_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic check_reset_vals();
    check("reset_flags", {26'd0, in_ready, mem_we, cpu_rst, busy, done, error}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wd", mem_wd, 32'd0);
    check("reset_words", {16'd0, words_loaded}, 32'd0);
  endtask

  // Returns the cycle number seen at the negedge preceding the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap_mode, output int acc_cyc);
    int waits = 0;
    if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_status(input bit exp_err, input int exp_cyc, input logic [15:0] exp_words);
    int k = 0;
    while (done !== 1'b1 && error !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("status_cycle", cyc, exp_cyc);
    check("status_flags", {27'd0, busy, in_ready, done, error, cpu_rst},
          exp_err ? 32'b00010 : 32'b00101);
    check("words_loaded", {16'd0, words_loaded}, {16'd0, exp_words});
    repeat (3) @(negedge clk);
    check("status_hold", {29'd0, done, error, cpu_rst}, exp_err ? 32'b010 : 32'b101);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  // Reference: a load of image img[0..n-1] writes word i to byte address 4*i,
  // one cycle after its 4th byte; lengths above MAXW are rejected.
  task automatic run_load(input logic [15:0] n, input int gap_mode, input bit bad_csum,
                          input bit poke_start, input int abort_bytes);
    int          c;
    int          nb;
    logic [7:0]  csum;
    logic [7:0]  b;
    logic [31:0] w;
    wr_t         e;
    nb   = 0;
    csum = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_status", {27'd0, busy, cpu_rst, done, error, in_ready}, 32'b10001);
    send_byte(n[15:8], gap_mode, c);
    send_byte(n[7:0], gap_mode, c);
    if (int'(n) > MAXW) begin
      expect_status(1'b1, c + 1, 16'd0);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        b = w[31-8*k -: 8];
        if (poke_start && i == 0 && k == 2) start = 1'b1;
        send_byte(b, gap_mode, c);
        start = 1'b0;
        csum = csum ^ b;
        nb++;
        if (k == 3) begin
          e.addr = 32'(4 * i);
          e.data = w;
          e.cyc  = c + 1;
          exp_q.push_back(e);
        end
        if (nb == abort_bytes) begin
          rst = 1'b0;
          @(negedge clk);
          check_reset_vals();
          rst = 1'b1;
          repeat (2) @(negedge clk);
          check("abort_queue_empty", exp_q.size(), 32'd0);
          return;
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? 8'hFF : csum, gap_mode, c);
    expect_status(bad_csum && (csum != 8'hFF), c + 1, n);
`else
    if (bad_csum) check("bad_csum_unsupported", 32'd1, 32'd0);
    if (n == 16'd0) begin
      expect_status(1'b0, c + 1, 16'd0);
    end else begin
      check("drain_in_ready", {31'd0, in_ready}, 32'd0);
      expect_status(1'b0, c + 2, n);
    end
`endif
  endtask

  task automatic set_spec_img();
    img.delete();
    img.push_back(32'h2408_0005);
    img.push_back(32'h2009_0003);
  endtask

  initial begin
    logic [15:0] n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (2) @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);

    set_spec_img();
    run_load(16'd2, 0, 1'b0, 1'b0, -1);
    run_load(16'd65, 0, 1'b0, 1'b0, -1);
    run_load(16'h0100, 2, 1'b0, 1'b0, -1);
    run_load(16'd0, 0, 1'b0, 1'b0, -1);
    run_load(16'd2, 1, 1'b0, 1'b0, -1);
    run_load(16'd2, 0, 1'b0, 1'b0, 6);
    run_load(16'd2, 0, 1'b0, 1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(16'd2, 0, 1'b1, 1'b0, -1);
    run_load(16'd2, 0, 1'b0, 1'b0, -1);
`endif

    for (int t = 0; t < 6; t++) begin
      n = (t == 0) ? 16'(MAXW) : 16'($urandom_range(1, MAXW));
      img.delete();
      for (int k = 0; k < int'(n); k++) img.push_back($urandom);
      run_load(n, 2, 1'b0, (t == 1), -1);
    end

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
